scope_capture_ctrl: RTL
=======================

Name: scope_capture_ctrl

Overview:
Sequences one oscilloscope acquisition from the 8-bit ADC bus into an on-chip sample buffer, then streams the buffer out through the UART transmitter.
- Capture phase: decimated sampling with a pre-trigger window, level/edge trigger and a forced-trigger override.
- Readout phase: one header byte followed by DEPTH samples, oldest first. Readout is paced by the UART busy flag using the active-low send strobe the UART already accepts.
- Sits between the ADC pins/top level and the uart instance, replacing free-running periodic sends.

Parameters:
- DEPTH, 256: buffer samples; power of two, 4..4096.
- AW, 8: address width, log2(DEPTH).
- PRE, 128: pre-trigger samples retained, 1..DEPTH-1.
- HEADER, 8'hA5: frame-start byte sent before the samples.

Ports:
- clk  in  1  system clock (27 MHz).
- rst  in  1  synchronous active-high reset.
- adc_data  in  8  ADC sample; adc_data[7] is the MSB.
- arm  in  1  one-cycle start request.
- force_trig  in  1  level; trigger immediately when in WAIT_TRIG.
- trig_level  in  8  trigger threshold, unsigned.
- trig_falling  in  1  0 = rising crossing, 1 = falling crossing.
- decim  in  16  keep one sample every decim+1 clocks; 0 = every clock.
- tx_busy  in  1  UART transmitting. The UART raises it the cycle after it sees tx_send_n low.
- tx_data  out  8  byte to transmit.
- tx_send_n  out  1  active-low one-cycle send strobe.
- state  out  3  current FSM state encoding.
- done  out  1  one-cycle pulse after the last byte is handed off.

Behaviour:
- Reset values: state=IDLE(0), tx_send_n=1, tx_data=0, done=0. Write pointer, counters, decimation counter and previous-sample register are all 0. Buffer contents are undefined.
- Sample strobe:
  - Decimation counter counts 0..decim, then wraps.
  - Strobe occurs when the counter equals decim.
  - Counter is cleared on arm acceptance.
  - decim is sampled at arm; later changes are ignored until the next arm.
- Only PRE_FILL, WAIT_TRIG and POST_FILL write the buffer. Each strobe writes adc_data at wr_ptr and advances wr_ptr modulo DEPTH.
- FSM:
  - IDLE(0): arm=1 -> PRE_FILL. Clear wr_ptr and fill counter; latch decim, trig_level and trig_falling.
  - PRE_FILL(1): after PRE strobes -> WAIT_TRIG.
  - WAIT_TRIG(2): buffer wraps freely. Trigger on a strobe when:
    - rising: prev < level and cur >= level;
    - falling: prev >= level and cur < level;
    - or force_trig=1.
    - The trigger sample itself is written; then go to POST_FILL with post count = DEPTH-PRE-1.
    - prev is the last strobed sample; in the first WAIT_TRIG strobe it is the final PRE_FILL sample.
  - POST_FILL(3): after DEPTH-PRE-1 further strobes -> SEND_HDR. rd_ptr = wr_ptr, which is the oldest sample.
  - SEND_HDR(4): when tx_busy=0 and not in hold-off, drive tx_data=HEADER and tx_send_n=0 for exactly one cycle -> SEND_DATA.
  - SEND_DATA(5):
    - Buffer read has 1-cycle latency; the read address is issued at least one cycle before the strobe.
    - Each handoff sends buf[rd_ptr] and increments rd_ptr mod DEPTH.
    - After DEPTH data bytes -> DONE.
  - DONE(6): done=1 for one cycle -> IDLE.
- Hold-off: for 2 cycles after any send strobe, tx_busy is ignored and no new strobe is issued. Strobes are therefore separated by at least 3 cycles plus the busy time.
- Frame length is exactly DEPTH+1 bytes. The trigger sample is data byte index PRE, zero-based after the header.
- arm outside IDLE is ignored. rst in any state returns to IDLE within one cycle with all outputs at reset values. An in-flight strobe is not repeated.
- force_trig and a real crossing on the same strobe count as one trigger.
- In PRE_FILL no trigger is evaluated, even with force_trig asserted.
- Simultaneous arm and rst: rst wins.

Test Plan:
- Ramp trigger: DEPTH=256, PRE=128, decim=0, rising, level 0x80; adc_data = ramp 0x00..0xFF wrapping; arm -> frame of 257 bytes: 0xA5, then byte[128]=0x80 with byte[127]=0x7F, and 256 consecutive ramp values.
- Falling edge: level 0x40, trig_falling=1; descending ramp -> data byte 128 = 0x3F and byte 127 = 0x40.
- Forced trigger: constant 0x10, force_trig held high -> trigger on the first WAIT_TRIG strobe; 257 bytes sent, all data bytes 0x10; done pulses once.
- Decimation: decim=3, ramp incrementing every clock -> consecutive data bytes differ by 4. PRE_FILL lasts 512 clocks; strobes are spaced 4 clocks apart.
- Busy pacing: UART model holds tx_busy for 10 cycles per byte -> no tx_send_n low while tx_busy=1 outside hold-off; strobes spaced 12 cycles; no byte dropped or duplicated.
- Reset and arm abuse: rst asserted at data byte 50 -> next cycle state=0 and tx_send_n=1; arm during POST_FILL is ignored; arm after DONE starts a fresh 257-byte frame.

Source files
------------

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope acquisition sequencer: decimated pre/post-trigger capture into a circular
// buffer, then readout of one header byte plus DEPTH samples (oldest first) through the UART.
module scope_capture_ctrl #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8,
  parameter int unsigned PRE    = 128,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  adc_data,
  input  logic        arm,
  input  logic        force_trig,
  input  logic [7:0]  trig_level,
  input  logic        trig_falling,
  input  logic [15:0] decim,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_send_n,
  output logic [2:0]  state,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPreFill  = 3'd1,
    StWaitTrig = 3'd2,
    StPostFill = 3'd3,
    StSendHdr  = 3'd4,
    StSendData = 3'd5,
    StDone     = 3'd6
  } stateT;

  localparam int PostLen = int'(DEPTH) - int'(PRE) - 1;
  localparam logic [AW-1:0] PreLast   = AW'(PRE - 1);
  localparam logic [AW-1:0] PostLast  = AW'(PostLen > 0 ? PostLen - 1 : 0);
  localparam logic [AW-1:0] DepthLast = AW'(DEPTH - 1);

  stateT         curState;
  logic [15:0]   decimCnt, decimLat;
  logic [7:0]    trigLevel, prevSample, rdData;
  logic          trigFalling;
  logic [AW-1:0] wrPtr, rdPtr, fillCnt, sentCnt;
  logic [1:0]    holdCnt;
  logic [7:0]    mem [DEPTH];

  logic capturing, sampleStb, crossing, trigHit, txReady;

  always_comb begin
    capturing = curState inside {StPreFill, StWaitTrig, StPostFill};
    sampleStb = capturing && (decimCnt == decimLat);
    crossing  = trigFalling ? (prevSample >= trigLevel && adc_data < trigLevel)
                            : (prevSample < trigLevel && adc_data >= trigLevel);
    trigHit   = crossing || force_trig;
    txReady   = (holdCnt == 2'd0) && !tx_busy;
  end

  // Registered read gives the 1-cycle latency; hold-off guarantees rdData settles before use.
  always_ff @(posedge clk) begin
    if (sampleStb && !rst) mem[wrPtr] <= adc_data;
    rdData <= mem[rdPtr];
  end

  assign state = curState;

  always_ff @(posedge clk) begin
    if (rst) begin
      curState    <= StIdle;
      tx_data     <= 8'd0;
      tx_send_n   <= 1'b1;
      done        <= 1'b0;
      decimCnt    <= '0;
      decimLat    <= '0;
      trigLevel   <= '0;
      trigFalling <= 1'b0;
      prevSample  <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fillCnt     <= '0;
      sentCnt     <= '0;
      holdCnt     <= '0;
    end else begin
      tx_send_n <= 1'b1;
      done      <= 1'b0;
      if (holdCnt != 2'd0) holdCnt <= holdCnt - 2'd1;
      if (capturing) begin
        decimCnt <= sampleStb ? 16'd0 : decimCnt + 16'd1;
        if (sampleStb) begin
          wrPtr      <= wrPtr + 1'b1;
          prevSample <= adc_data;
        end
      end
      unique case (curState)
        StIdle: begin
          if (arm) begin
            curState    <= StPreFill;
            wrPtr       <= '0;
            fillCnt     <= '0;
            decimCnt    <= '0;
            decimLat    <= decim;
            trigLevel   <= trig_level;
            trigFalling <= trig_falling;
          end
        end
        StPreFill: begin
          if (sampleStb) begin
            fillCnt <= fillCnt + 1'b1;
            if (fillCnt == PreLast) curState <= StWaitTrig;
          end
        end
        StWaitTrig: begin
          if (sampleStb && trigHit) begin
            fillCnt <= '0;
            if (PostLen == 0) begin
              curState <= StSendHdr;
              rdPtr    <= wrPtr + 1'b1;
            end else begin
              curState <= StPostFill;
            end
          end
        end
        StPostFill: begin
          if (sampleStb) begin
            fillCnt <= fillCnt + 1'b1;
            if (fillCnt == PostLast) begin
              curState <= StSendHdr;
              // Slot after the final write is the oldest sample in the ring.
              rdPtr    <= wrPtr + 1'b1;
            end
          end
        end
        StSendHdr: begin
          if (txReady) begin
            tx_data   <= HEADER;
            tx_send_n <= 1'b0;
            holdCnt   <= 2'd2;
            sentCnt   <= '0;
            curState  <= StSendData;
          end
        end
        StSendData: begin
          if (txReady) begin
            tx_data   <= rdData;
            tx_send_n <= 1'b0;
            holdCnt   <= 2'd2;
            rdPtr     <= rdPtr + 1'b1;
            sentCnt   <= sentCnt + 1'b1;
            if (sentCnt == DepthLast) begin
              curState <= StDone;
              done     <= 1'b1;
            end
          end
        end
        StDone:  curState <= StIdle;
        default: curState <= StIdle;
      endcase
    end
  end

endmodule
